// File: rtl/pwm_speed_ramp.sv
// rtl/pwm_speed_ramp.sv - debounced push-button speed control with soft ramp for the PWM block
// Optional feature macro: PWM_RAMP_BYPASS_EN (adds ramp_bypass input, speed follows target directly)
module pwm_speed_ramp #(
  parameter int DEB_CYCLES  = 200000,
  parameter int RAMP_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
`ifdef PWM_RAMP_BYPASS_EN
  input  logic       ramp_bypass,
`endif
  output logic [2:0] speed,
  output logic       pwm_en,
  output logic       busy,
  output logic [2:0] target
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RW = $clog2(RAMP_CYCLES);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  // Button index: 0 = up, 1 = down, 2 = stop
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [DW-1:0] deb_cnt [3];
  logic [1:0]    deb_d;
  logic          up_evt;
  logic          dn_evt;
  logic          stop_q;

  state_t        state;
  state_t        next_state;
  logic [RW-1:0] ramp_cnt;
  logic [RW-1:0] next_cnt;
  logic [2:0]    next_speed;
  logic [2:0]    next_target;

  assign raw = {btn_stop, btn_down, btn_up};

  genvar i;
  for (i = 0; i < 3; i++) begin : g_deb
    // Two-flop synchronizer plus stable-level counter; level flips only after DEB_CYCLES differing clocks
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1[i]   <= 1'b0;
        sync2[i]   <= 1'b0;
        deb[i]     <= 1'b0;
        deb_cnt[i] <= '0;
      end else begin
        sync1[i] <= raw[i];
        sync2[i] <= sync1[i];
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered press pulses for up/down and an aligned copy of the stop level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d  <= 2'b00;
      up_evt <= 1'b0;
      dn_evt <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      deb_d  <= deb[1:0];
      up_evt <= deb[0] & ~deb_d[0];
      dn_evt <= deb[1] & ~deb_d[1];
      stop_q <= deb[2];
    end
  end

  // Requested speed: stop dominates, opposing presses cancel, saturate at both ends
  always_comb begin
    next_target = target;
    if (stop_q) begin
      next_target = 3'd0;
    end else if (up_evt && !dn_evt) begin
      if (target != 3'd7) next_target = target + 3'd1;
    end else if (dn_evt && !up_evt) begin
      if (target != 3'd0) next_target = target - 3'd1;
    end
  end

  // Holds the debounced requested speed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) target <= 3'd0;
    else        target <= next_target;
  end

  // Ramp step decision; state mirrors the current speed/target relation
  always_comb begin
    next_speed = speed;
    next_cnt   = '0;
    case (state)
      RAMP_UP, RAMP_DOWN: begin
        if (ramp_cnt == RW'(RAMP_CYCLES - 1)) begin
          next_cnt   = '0;
          next_speed = (state == RAMP_UP) ? speed + 3'd1 : speed - 3'd1;
        end else begin
          next_cnt = ramp_cnt + 1'b1;
        end
      end
      default: next_cnt = '0;
    endcase
`ifdef PWM_RAMP_BYPASS_EN
    if (ramp_bypass) begin
      next_speed = target;
      next_cnt   = '0;
    end
`endif
    if (next_speed == next_target) next_cnt = '0;
    if (next_target > next_speed)      next_state = RAMP_UP;
    else if (next_target < next_speed) next_state = RAMP_DOWN;
    else                               next_state = IDLE;
  end

  // Ramp FSM with registered speed, enable and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ramp_cnt <= '0;
      speed    <= 3'd0;
      pwm_en   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      ramp_cnt <= next_cnt;
      speed    <= next_speed;
      pwm_en   <= (next_speed != 3'd0);
      busy     <= (next_speed != next_target);
    end
  end

endmodule

// File: tb/tb_pwm_speed_ramp.sv
// tb/tb_pwm_speed_ramp.sv - directed self-checking bench for pwm_speed_ramp
module tb_pwm_speed_ramp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_stop = 1'b0;
`ifdef PWM_RAMP_BYPASS_EN
  logic       ramp_bypass = 1'b0;
`endif
  logic [2:0] speed;
  logic       pwm_en;
  logic       busy;
  logic [2:0] target;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_speed_ramp #(.DEB_CYCLES(4), .RAMP_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_stop (btn_stop),
`ifdef PWM_RAMP_BYPASS_EN
    .ramp_bypass (ramp_bypass),
`endif
    .speed    (speed),
    .pwm_en   (pwm_en),
    .busy     (busy),
    .target   (target)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic press(input logic u, input logic d);
    btn_up = u; btn_down = d;
    step(6);
    btn_up = 1'b0; btn_down = 1'b0;
    step(8);
  endtask

  task automatic wait_settle(input int max);
    int k;
    k = 0;
    while ((busy !== 1'b0 || speed !== target) && k < max) begin
      step(1);
      k++;
    end
    checks++;
    if (k >= max) begin
      errors++;
      $display("FAIL settle_timeout: speed=%0d target=%0d busy=%0b after %0d cycles", speed, target, busy, k);
    end
  endtask

  task automatic test_reset();
    int bad;
    apply_reset();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      checks++;
      if (speed !== 3'd0 || target !== 3'd0 || pwm_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL reset_idle: cycle %0d speed=%0d target=%0d pwm_en=%0b busy=%0b expected all 0", c, speed, target, pwm_en, busy);
      end
    end
  endtask

  task automatic test_single_step();
    apply_reset();
    btn_up = 1'b1;
    step(7);
    checks++; if (target !== 3'd0) begin errors++; $display("FAIL tgt_E6: got %0d expected 0", target); end
    step(1);
    checks++; if (target !== 3'd1) begin errors++; $display("FAIL tgt_E7: got %0d expected 1", target); end
    step(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_E8: got %0b expected 1", busy); end
    checks++; if (speed !== 3'd0) begin errors++; $display("FAIL speed_E8: got %0d expected 0", speed); end
    step(1);
    btn_up = 1'b0;
    step(5);
    checks++; if (speed !== 3'd0 || pwm_en !== 1'b0) begin errors++; $display("FAIL speed_E14: got speed=%0d pwm_en=%0b expected 0/0", speed, pwm_en); end
    step(1);
    checks++; if (speed !== 3'd1) begin errors++; $display("FAIL speed_E15: got %0d expected 1", speed); end
    checks++; if (pwm_en !== 1'b1) begin errors++; $display("FAIL pwm_en_E15: got %0b expected 1", pwm_en); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_E16: got %0b expected 0", busy); end
  endtask

  task automatic test_glitch_saturate();
    apply_reset();
    repeat (5) begin
      btn_up = 1'b1;
      step(3);
      btn_up = 1'b0;
      step(5);
    end
    step(10);
    checks++; if (target !== 3'd0) begin errors++; $display("FAIL glitch_target: got %0d expected 0", target); end
    repeat (9) press(1'b1, 1'b0);
    checks++; if (target !== 3'd7) begin errors++; $display("FAIL saturate_target: got %0d expected 7", target); end
    wait_settle(200);
    checks++; if (speed !== 3'd7 || pwm_en !== 1'b1) begin errors++; $display("FAIL saturate_speed: got speed=%0d pwm_en=%0b expected 7/1", speed, pwm_en); end
  endtask

  task automatic test_stop();
    apply_reset();
    repeat (5) press(1'b1, 1'b0);
    wait_settle(200);
    checks++; if (speed !== 3'd5 || target !== 3'd5) begin errors++; $display("FAIL stop_setup: got speed=%0d target=%0d expected 5/5", speed, target); end
    btn_stop = 1'b1;
    step(7);
    checks++; if (target !== 3'd5) begin errors++; $display("FAIL stop_tgt_E6: got %0d expected 5", target); end
    step(1);
    checks++; if (target !== 3'd0) begin errors++; $display("FAIL stop_tgt_E7: got %0d expected 0", target); end
    step(7);
    checks++; if (speed !== 3'd5) begin errors++; $display("FAIL stop_speed_S7: got %0d expected 5", speed); end
    step(1);
    checks++; if (speed !== 3'd4) begin errors++; $display("FAIL stop_speed_S8: got %0d expected 4", speed); end
    step(31);
    checks++; if (speed !== 3'd1 || pwm_en !== 1'b1) begin errors++; $display("FAIL stop_speed_S39: got speed=%0d pwm_en=%0b expected 1/1", speed, pwm_en); end
    step(1);
    checks++; if (speed !== 3'd0 || pwm_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_speed_S40: got speed=%0d pwm_en=%0b busy=%0b expected 0/0/0", speed, pwm_en, busy); end
    press(1'b1, 1'b0);
    checks++; if (target !== 3'd0) begin errors++; $display("FAIL stop_up_ignored: got %0d expected 0", target); end
    btn_stop = 1'b0;
    step(12);
    checks++; if (target !== 3'd0 || speed !== 3'd0) begin errors++; $display("FAIL stop_release: got target=%0d speed=%0d expected 0/0", target, speed); end
  endtask

  task automatic test_reversal();
    apply_reset();
    repeat (2) press(1'b1, 1'b0);
    wait_settle(200);
    repeat (4) press(1'b1, 1'b0);
    checks++; if (target !== 3'd6) begin errors++; $display("FAIL rev_target6: got %0d expected 6", target); end
    repeat (2) press(1'b0, 1'b1);
    checks++; if (target !== 3'd4) begin errors++; $display("FAIL rev_target4: got %0d expected 4", target); end
    press(1'b0, 1'b1);
    checks++; if (target !== 3'd3) begin errors++; $display("FAIL rev_target3: got %0d expected 3", target); end
    wait_settle(200);
    checks++; if (speed !== 3'd3 || busy !== 1'b0) begin errors++; $display("FAIL rev_settle: got speed=%0d busy=%0b expected 3/0", speed, busy); end
    press(1'b1, 1'b1);
    checks++; if (target !== 3'd3) begin errors++; $display("FAIL simultaneous: got %0d expected 3", target); end
    step(20);
    checks++; if (speed !== 3'd3 || busy !== 1'b0) begin errors++; $display("FAIL simultaneous_speed: got speed=%0d busy=%0b expected 3/0", speed, busy); end
  endtask

`ifdef PWM_RAMP_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    ramp_bypass = 1'b1;
    btn_up = 1'b1;
    step(8);
    checks++; if (target !== 3'd1 || speed !== 3'd0) begin errors++; $display("FAIL bypass_E7: got target=%0d speed=%0d expected 1/0", target, speed); end
    step(1);
    checks++; if (speed !== 3'd1 || pwm_en !== 1'b1) begin errors++; $display("FAIL bypass_E8: got speed=%0d pwm_en=%0b expected 1/1", speed, pwm_en); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_busy: got %0b expected 0", busy); end
    btn_up = 1'b0;
    step(10);
    ramp_bypass = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    apply_reset();
    repeat (3) press(1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || target !== 3'd3 || speed !== 3'd2) begin errors++; $display("FAIL midramp_setup: got busy=%0b target=%0d speed=%0d expected 1/3/2", busy, target, speed); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (speed !== 3'd0 || target !== 3'd0 || pwm_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset: got speed=%0d target=%0d pwm_en=%0b busy=%0b expected all 0", speed, target, pwm_en, busy); end
    step(2);
    rst_n = 1'b1;
    step(20);
    checks++; if (speed !== 3'd0 || target !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL after_reset: got speed=%0d target=%0d busy=%0b expected 0/0/0", speed, target, busy); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_glitch_saturate();
    test_stop();
    test_reversal();
`ifdef PWM_RAMP_BYPASS_EN
    test_bypass();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
